// File: rtl/arcabuco_uart_rx.sv
// arcabuco_uart_rx: 8N1 UART receiver with a small receive FIFO and
// a registered DATA/STATUS read port.
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   rx_pad              - asynchronous serial input, idles high
//   rd_en, addr         - read strobe; addr 0 = DATA, 1 = STATUS
//   rd_data             - registered read data (one-cycle latency)
//   rx_valid            - FIFO not empty
module arcabuco_uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_pad,
    input  logic        rd_en,
    input  logic        addr,
    output logic [31:0] rd_data,
    output logic        rx_valid
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q, sync_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      sh_q, sh_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic [31:0]     rd_data_q, rd_data_d;

    logic rx_s;
    logic push;
    logic frame_evt;
    logic empty;
    logic full;
    logic pop;
    logic wr;
    logic ovr_evt;
    logic status_rd;

    assign sync_d = {sync_q[0], rx_pad};
    assign rx_s   = sync_q[1];

    // Receive FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        push      = 1'b0;
        frame_evt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    // A high level at mid start bit is a glitch.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d       = '0;
                    sh_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        push = 1'b1;
                    end else begin
                        frame_evt = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO, flags and read port
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                   (wptr_q[AW] != rptr_q[AW]);
    assign pop       = rd_en && !addr && !empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign wr        = push && (!full || pop);
    assign ovr_evt   = push && full && !pop;
    assign status_rd = rd_en && addr;

    always_comb begin
        mem_d = mem_q;
        if (wr) begin
            mem_d[wptr_q[AW-1:0]] = sh_q;
        end
        wptr_d = wr  ? wptr_q + PW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
        // New error events win over a clear-on-read.
        frame_err_d = (frame_err_q && !status_rd) || frame_evt;
        overrun_d   = (overrun_q && !status_rd) || ovr_evt;
        rd_data_d = rd_data_q;
        if (rd_en) begin
            if (addr) begin
                rd_data_d = {28'b0, frame_err_q, overrun_q, full, !empty};
            end else if (!empty) begin
                rd_data_d = {24'b0, mem_q[rptr_q[AW-1:0]]};
            end else begin
                rd_data_d = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign rd_data  = rd_data_q;
    assign rx_valid = !empty;

endmodule
